load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 256: number of 64-bit words in the attached data memory.
REQ-002 The block SHALL have parameter ROM_SIZE, default 2: the lowest ROM_SIZE words are read-only.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  pipeline presents a load/store request.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-010 req_signed  input  1  sign-extend loaded data; ignored for stores and dword loads.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  64  store data, right-aligned in bits [8*bytes-1:0].
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_rdata  output  64  load result, valid with resp_valid.
REQ-015 resp_err  output  1  request rejected, valid with resp_valid.
REQ-016 mem_addr  output  32  word address to data memory: req_addr[31:3], zero-extended.
REQ-017 mem_wr_data  output  64  write data to data memory.
REQ-018 mem_wr_enable  output  1  memory write strobe; memory writes on the same rising edge.
REQ-019 mem_rd_enable  output  1  memory read strobe.
REQ-020 mem_rd_data  input  64  combinational memory read data for mem_addr.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-022 In IDLE, a request is accepted when req_valid && req_ready; all req_* fields are latched.
REQ-023 The request SHALL be rejected to RESP with resp_err = 1 if any holds: req_addr not aligned to its size; word address >= MEM_SIZE; store with word address < ROM_SIZE.
REQ-024 A rejected request SHALL generate no memory access.
REQ-025 On acceptance: a load goes to ACCESS; a dword store goes to WRITE; a sub-dword store goes to ACCESS.
REQ-026 ACCESS: mem_rd_enable = 1; mem_rd_data is captured at the edge. A load then goes to RESP; a store merges its bytes and goes to WRITE.
REQ-027 Merge: bytes at little-endian lane offset req_addr[2:0] are replaced by req_wdata; all other bytes are preserved.
REQ-028 WRITE: mem_wr_enable = 1 for exactly one cycle, mem_wr_data = merged (or full) data; then RESP.
REQ-029 RESP: resp_valid = 1 for exactly one cycle with no backpressure; then IDLE.
REQ-030 Load result: extract the size-wide field at lane offset, then sign-extend (req_signed) or zero-extend to 64 bits.
REQ-031 resp_rdata SHALL be 0 for stores and errors; resp_err SHALL be 0 on success.
REQ-032 Latency, with acceptance in cycle T, resp_valid SHALL assert in:
- error: T+1
- load: T+2
- dword store: T+2
- sub-dword store: T+3
REQ-033 mem_wr_enable and mem_rd_enable SHALL be 0 outside WRITE and ACCESS; they are never asserted together.
REQ-034 mem_addr SHALL hold the last latched word address when idle.
REQ-035 A new request can be accepted in the cycle after RESP.

Reset
REQ-036 While rst = 0, the block SHALL immediately set state = IDLE and drive all outputs to 0, except req_ready = 1.
REQ-037 Reset SHALL clear all latched request and data registers to 0.
REQ-038 Reset asserted mid-operation SHALL abort the access with no response.
REQ-039 Reset asserted during WRITE SHALL drop mem_wr_enable asynchronously.

Structure
REQ-040 The shared package lsu_pkg SHALL hold the size encoding enum (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-041 The combinational extract/extend and merge logic SHALL live in the sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-042 Word 2 preloaded 0x1122334455667788; dword load from 0x10 -> resp_rdata = 0x1122334455667788 at T+2, resp_err = 0.
REQ-043 Same data; signed byte load from 0x10 -> 0xFFFFFFFFFFFFFF88; unsigned -> 0x0000000000000088.
REQ-044 Half store 0xBEEF to 0x12 -> mem_rd_enable at T+1, mem_wr_enable exactly at T+2, word 2 = 0x11223344BEEF7788, resp_valid at T+3.
REQ-045 Dword store to 0x08 (ROM); word load from 0x12 (misaligned); load from 0x800 -> each gives resp_err = 1 at T+1 with no mem_*_enable pulse.
REQ-046 rst pulled low during WRITE -> mem_wr_enable = 0 the same cycle, no resp_valid; after release req_ready = 1 and a following load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size and FSM encodings shared by the load/store unit files.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;
  function automatic logic [63:0] size_mask(size_e s);
    return s == SZ_B ? 64'hFF : s == SZ_H ? 64'hFFFF : s == SZ_W ? 64'hFFFF_FFFF : {64{1'b1}};
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load field extract/extend and store byte-lane merge within one 64-bit word.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] merge_o
);
  logic [63:0] mask, field, lane_mask;
  logic [5:0]  sh;
  logic        msb;
  always_comb begin
    mask      = size_mask(size_i);
    sh        = {off_i, 3'b000};
    field     = (rdata_i >> sh) & mask;
    msb       = |(field & mask & ~(mask >> 1));  // top bit of the access-sized field
    load_o    = field | ((signed_i && msb) ? ~mask : 64'd0);
    lane_mask = mask << sh;
    merge_o   = (rdata_i & ~lane_mask) | ((wdata_i << sh) & lane_mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with alignment, bounds and ROM checks.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 256,
  parameter int ROM_SIZE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic        mem_rd_enable,
  input  logic [63:0] mem_rd_data
);
  state_e      state_q;
  size_e       size_q;
  logic        we_q, signed_q, err_q, ready_q, rd_en_q, wr_en_q, valid_q;
  logic [31:0] addr_q;
  logic [63:0] data_q, rdata_q, load_data, merged;
  logic        misaligned, out_of_range, rom_store, reject, full_store;
  logic [2:0]  low_mask;
  always_comb begin
    low_mask     = 3'((4'd1 << req_size) - 4'd1);
    misaligned   = |(req_addr[2:0] & low_mask);
    out_of_range = {3'b000, req_addr[31:3]} >= 32'(MEM_SIZE);
    rom_store    = req_we && {3'b000, req_addr[31:3]} < 32'(ROM_SIZE);
    reject       = misaligned || out_of_range || rom_store;
    full_store   = req_we && req_size == 2'd3;
  end
  // data_q carries store data until ACCESS, then the merged word written in WRITE
  lsu_align u_align (
    .size_i  (size_q),
    .signed_i(signed_q),
    .off_i   (addr_q[2:0]),
    .rdata_i (mem_rd_data),
    .wdata_i (data_q),
    .load_o  (load_data),
    .merge_o (merged)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      size_q   <= SZ_B;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          size_q   <= size_e'(req_size);
          signed_q <= req_signed;
          addr_q   <= req_addr;
          data_q   <= req_wdata;
          rdata_q  <= '0;
          err_q    <= reject;
          ready_q  <= 1'b0;
          valid_q  <= reject;
          rd_en_q  <= !reject && !full_store;
          wr_en_q  <= !reject && full_store;
          state_q  <= reject ? RESP : full_store ? WRITE : ACCESS;
        end
        ACCESS: begin
          rd_en_q <= 1'b0;
          wr_en_q <= we_q;
          valid_q <= !we_q;
          data_q  <= we_q ? merged : data_q;
          rdata_q <= we_q ? 64'd0 : load_data;
          state_q <= we_q ? WRITE : RESP;
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready     = ready_q;
  assign resp_valid    = valid_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_addr      = {3'b000, addr_q[31:3]};
  assign mem_wr_data   = data_q;
  assign mem_wr_enable = wr_en_q;
  assign mem_rd_enable = rd_en_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_wr_enable, mem_rd_enable;
  logic [63:0] resp_rdata, mem_wr_data, mem_rd_data;
  logic [31:0] mem_addr;
  logic [63:0] mem [256];
  logic [63:0] ref_mem [256];
  int n_cmp = 0, n_fail = 0;

  load_store_unit #(.MEM_SIZE(256), .ROM_SIZE(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr_enable) mem[mem_addr[7:0]] <= mem_wr_data;

  // Drives one request and watches the bus until the response (cycle 1 = first cycle after acceptance).
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [63:0] wd, output int lat, output logic [63:0] rd, output logic er,
                       output int rd_at, output int wr_at, output int wr_cnt, output logic both,
                       output logic rdy);
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0; rd_at = 0; wr_at = 0; wr_cnt = 0; both = 1'b0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      if (mem_rd_enable && rd_at == 0) rd_at = n;
      if (mem_wr_enable) begin wr_cnt++; wr_at = n; end
      both = both | (mem_rd_enable & mem_wr_enable);
      if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; end
      else @(negedge clk);
    end
  endtask

  // Reference: byte-by-byte view of memory, applies stores to ref_mem.
  task automatic ref_access(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                            input logic [63:0] wd, output logic er, output logic [63:0] rd, output int lat);
    int nb, w, off;
    nb = 1 << sz; w = int'(a >> 3); off = int'(a % 8);
    er = (a % nb) != 0 || (a >> 3) >= 256 || (we && (a >> 3) < 2);
    rd = '0;
    if (er) lat = 1;
    else if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[w][8*(off+i) +: 8] = wd[8*i +: 8];
      lat = (nb == 8) ? 2 : 3;
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[w][8*(off+i) +: 8];
      if (sg && nb < 8 && rd[8*nb-1]) for (int i = nb; i < 8; i++) rd[8*i +: 8] = 8'hFF;
      lat = 2;
    end
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_cmp++; if ({resp_valid, resp_err, mem_wr_enable, mem_rd_enable} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {resp_valid, resp_err, mem_wr_enable, mem_rd_enable}); end
    n_cmp++; if ({resp_rdata, mem_wr_data, mem_addr} !== '0) begin n_fail++;
      $display("FAIL reset_data got %h %h %h exp 0", resp_rdata, mem_wr_data, mem_addr); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_directed;
    int lat, rd_at, wr_at, wr_cnt; logic [63:0] rd; logic er, both, rdy;
    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];
    logic        bad_we [3];
    mem[2] <= 64'h1122334455667788; ref_mem[2] = 64'h1122334455667788;
    @(negedge clk);
    issue(1'b0, 2'd3, 1'b0, 32'h10, '0, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
    n_cmp++; if (rd !== 64'h1122334455667788 || er !== 1'b0 || lat != 2) begin n_fail++;
      $display("FAIL dword_load got %h err %b lat %0d exp 1122334455667788 0 2", rd, er, lat); end
    issue(1'b0, 2'd0, 1'b1, 32'h10, '0, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
    n_cmp++; if (rd !== 64'hFFFFFFFFFFFFFF88 || er !== 1'b0) begin n_fail++;
      $display("FAIL signed_byte got %h exp ffffffffffffff88", rd); end
    issue(1'b0, 2'd0, 1'b0, 32'h10, '0, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
    n_cmp++; if (rd !== 64'h88 || er !== 1'b0) begin n_fail++;
      $display("FAIL unsigned_byte got %h exp 0000000000000088", rd); end
    issue(1'b1, 2'd1, 1'b0, 32'h12, 64'hBEEF, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
    ref_mem[2] = 64'h11223344BEEF7788;
    n_cmp++; if (rd_at != 1 || wr_at != 2 || wr_cnt != 1 || lat != 3 || er !== 1'b0) begin n_fail++;
      $display("FAIL half_store_timing got rd %0d wr %0d x%0d lat %0d exp 1 2 x1 3", rd_at, wr_at, wr_cnt, lat); end
    n_cmp++; if (mem[2] !== 64'h11223344BEEF7788) begin n_fail++;
      $display("FAIL half_store_data got %h exp 11223344beef7788", mem[2]); end
    bad_addr = '{32'h08, 32'h12, 32'h800}; bad_size = '{2'd3, 2'd2, 2'd3}; bad_we = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(bad_we[i], bad_size[i], 1'b0, bad_addr[i], 64'hDEAD, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
      n_cmp++; if (er !== 1'b1 || lat != 1 || rd_at != 0 || wr_cnt != 0 || rd !== '0) begin n_fail++;
        $display("FAIL reject_%0d got err %b lat %0d rd %0d wr %0d data %h exp 1 1 0 0 0", i, er, lat, rd_at, wr_cnt, rd); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, rd_at, wr_at, wr_cnt; logic [63:0] rd; logic er, both, rdy;
    issue(1'b0, 2'd3, 1'b0, 32'h18, '0, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL after_resp got valid %b ready %b exp 0 1", resp_valid, req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h1C;
    @(negedge clk); req_valid = 1'b0;
    n_cmp++; if (mem_rd_enable !== 1'b1 || req_ready !== 1'b0) begin n_fail++;
      $display("FAIL accept_after_resp got rd_en %b ready %b exp 1 0", mem_rd_enable, req_ready); end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== {32'd0, ref_mem[3][63:32]}) begin n_fail++;
      $display("FAIL b2b_load got %b %h exp 1 %h", resp_valid, resp_rdata, {32'd0, ref_mem[3][63:32]}); end
  endtask

  task automatic test_random;
    int lat, rd_at, wr_at, wr_cnt, e_lat; logic [63:0] rd, e_rd, wd; logic er, both, rdy, e_er, we, sg;
    logic [1:0] sz; logic [31:0] a; logic [2:0] off;
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); wd = {$urandom, $urandom};
      off = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(($urandom % 8) & ~((1 << sz) - 1));
      a = {21'd0, 8'($urandom_range(0, 255)), off};
      if ($urandom_range(0, 15) == 0) a = $urandom;
      if (!we) wd = '0;
      ref_access(we, sz, sg, a, wd, e_er, e_rd, e_lat);
      issue(we, sz, sg, a, wd, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
      n_cmp++; if (lat != e_lat || er !== e_er || rd !== e_rd) begin n_fail++;
        $display("FAIL rand_%0d resp got lat %0d err %b data %h exp %0d %b %h (we %b sz %0d a %h)",
                 k, lat, er, rd, e_lat, e_er, e_rd, we, sz, a); end
      n_cmp++; if (rd_at != ((!e_er && !(we && sz == 2'd3)) ? 1 : 0) ||
                   wr_cnt != ((!e_er && we) ? 1 : 0) || wr_at != ((!e_er && we) ? e_lat - 1 : 0) || both || !rdy) begin
        n_fail++;
        $display("FAIL rand_%0d bus got rd %0d wr %0d x%0d both %b ready %b", k, rd_at, wr_at, wr_cnt, both, rdy); end
    end
  endtask

  task automatic test_reset_mid_write;
    int n, lat, rd_at, wr_at, wr_cnt; logic [63:0] rd; logic er, both, rdy, seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h40; req_wdata = {$urandom, $urandom};
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    while (!mem_wr_enable && n < 8) begin @(negedge clk); n++; end
    n_cmp++; if (mem_wr_enable !== 1'b1) begin n_fail++; $display("FAIL write_reached got %b exp 1", mem_wr_enable); end
    #1 rst = 1'b0; #1;
    n_cmp++; if (mem_wr_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL async_abort got wr %b ready %b valid %b exp 0 1 0", mem_wr_enable, req_ready, resp_valid); end
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | resp_valid; end
    n_cmp++; if (seen !== 1'b0 || mem[8] !== ref_mem[8]) begin n_fail++;
      $display("FAIL abort_effects got resp %b word %h exp 0 %h", seen, mem[8], ref_mem[8]); end
    issue(1'b0, 2'd3, 1'b0, 32'h40, '0, lat, rd, er, rd_at, wr_at, wr_cnt, both, rdy);
    n_cmp++; if (!rdy || lat != 2 || er !== 1'b0 || rd !== ref_mem[8]) begin n_fail++;
      $display("FAIL load_after_reset got ready %b lat %0d err %b data %h exp 1 2 0 %h", rdy, lat, er, rd, ref_mem[8]); end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      mem[i] <= ref_mem[i];
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL final_memory got %0d differing words exp 0", bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
